usb_tx_timer: RTL and testbench
===============================

Name: usb_tx_timer

Overview:
- Bit/byte timing controller for the USB transmit path.
- Runs a clock-divider counter and a bit counter (both flex_counter instances). Produces one-cycle shift strobes at the bit rate and a byte-complete pulse for the Tx shift register and Tx FSM.
- Absorbs bit-stuff requests by spending a bit time without advancing the bit count.
- Tx controller drives start/stop; the shift register and encoder consume the strobes.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit time; legal range 2..15.
- BITS_PER_BYTE, 8, data bits per byte before byte_done; legal range 2..15.
- CNT_BITS, 4, width of both internal counters; must hold CLKS_PER_BIT and BITS_PER_BYTE.

Ports:
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  level, sampled in IDLE; begins timing
- stop  in  1  level, sampled in RUN; finish current byte then halt
- abort  in  1  synchronous abort; return to IDLE next edge
- stuff_req  in  1  sampled on shift_strobe cycle; next bit time is a stuffed bit
- shift_strobe  out  1  one-cycle pulse at end of each bit time
- byte_done  out  1  one-cycle pulse coincident with strobe that completes last data bit
- bit_index  out  CNT_BITS  data bits completed in current byte, 0..BITS_PER_BYTE-1
- stuff_active  out  1  high for the full duration of a stuffed bit time
- busy  out  1  high in any state other than IDLE
- eop_se0  out  1  SE0 drive request (TX_EOP_EN only; else constant 0)

Behaviour:
- Reset (n_rst low, async): state IDLE; both counters 0; all outputs 0; stop latch 0.
- FSM states: IDLE, RUN, EOP (EOP exists only with TX_EOP_EN).
- IDLE -> RUN: on an edge with start=1.
  - Clock counter and bit counter cleared.
  - busy=1 from the next cycle.
- RUN clocking:
  - Clock counter counts 1..CLKS_PER_BIT (rollover_val = CLKS_PER_BIT).
  - shift_strobe is asserted on the cycle the clock counter equals CLKS_PER_BIT.
  - First strobe occurs exactly CLKS_PER_BIT cycles after the start edge; later strobes every CLKS_PER_BIT cycles, with no gaps across byte boundaries.
- Strobe with stuff_req=0 and stuff_active=0: bit counter increments.
  - When it reaches BITS_PER_BYTE, byte_done pulses with that same strobe and bit_index wraps to 0.
- Strobe with stuff_req=1:
  - Still counts as a data bit (increments as above).
  - stuff_active goes high next cycle for exactly one bit time; the strobe ending that bit time does not increment the bit counter.
  - stuff_req is ignored while stuff_active=1.
- Stuffed bit following the last data bit: byte_done still pulses on the data strobe. The stuffed bit time elapses before the next byte's first bit, or before halt/EOP.
- stop handling:
  - Any stop=1 in RUN sets a stop latch, cleared on leaving RUN.
  - At byte_done with the latch set, or with stop=1 on that cycle: go to EOP (feature on) or IDLE (feature off).
  - If a stuffed bit is pending, the transition waits until its strobe.
- start while not IDLE: ignored.
- start and stop both high in IDLE: enter RUN and set the latch; exactly one byte is timed.
- abort: highest priority in every state. Next edge: IDLE, counters 0, stop latch 0, outputs 0. No byte_done is generated.
- Output registering: all outputs registered. bit_index equals the bit counter value.

Optional Feature:
- Macro: TX_EOP_TIMER_EN
- Defined:
  - EOP state lasts 3*CLKS_PER_BIT cycles.
  - eop_se0=1 for the first 2 bit times, 0 for the third (J idle).
  - shift_strobe still pulses each bit time; bit_index stays 0.
  - Then IDLE; busy drops the cycle after the third strobe.
- Undefined: no EOP state; eop_se0 tied 0; RUN goes directly to IDLE.

Decomposition:
- Shared package usb_tx_pkg:
  - State enum type tx_timer_state_t {IDLE, RUN, EOP}
  - Constants USB_CLKS_PER_BIT=8, USB_BITS_PER_BYTE=8, USB_EOP_BITS=3
- Sub-module: existing flex_counter, instantiated twice (clock divider, bit counter); rollover_flag/count_out feed the FSM.
- EOP bit count reuses the bit-counter instance with rollover_val muxed to 3.

Test Plan:
- Reset mid-RUN (n_rst low at cycle 13) -> all outputs 0 immediately; no strobe after release until a new start.
- start pulse at cycle 0, stop held high -> strobes at cycles 8,16,...,64; byte_done only at 64; busy low from cycle 65 (no EOP).
- stuff_req=1 on 3rd strobe (cycle 24) -> stuff_active high cycles 25-32; strobe at 32 leaves bit_index=3; byte_done moves to cycle 72.
- Continuous run, stop asserted at cycle 70 -> byte_done at 64 and 128; IDLE after 128; no strobe at 136.
- abort at cycle 40 -> busy=0, bit_index=0 at 41; no byte_done; start at 50 -> first strobe at 58.
- TX_EOP_TIMER_EN, one byte -> eop_se0 high cycles 65-80, low 81-88; busy low at 89.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared state type and default timing constants for the USB transmit path.
package usb_tx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      EOP  = 2'd2
   } tx_timer_state_t;

   localparam int USB_CLKS_PER_BIT  = 8;
   localparam int USB_BITS_PER_BYTE = 8;
   localparam int USB_EOP_BITS      = 3;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with clear and programmable rollover; the flag is registered
// and is high for exactly the cycles in which count_out equals rollover_val.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_q, count_d;
   logic                    flag_q, flag_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = (count_q == rollover_val) ? NUM_CNT_BITS'(1) : count_q + NUM_CNT_BITS'(1);
      end
      flag_d = (count_d == rollover_val);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         flag_q  <= flag_d;
      end
   end

   assign count_out     = count_q;
   assign rollover_flag = flag_q;

endmodule

// File: rtl/usb_tx_timer.sv
// USB transmit bit/byte timer: bit-rate shift strobes, byte_done, bit-stuff absorption.
// Define TX_EOP_TIMER_EN to add the three-bit-time EOP state driving eop_se0.
module usb_tx_timer
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
   parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE,
   parameter int CNT_BITS      = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic                stop,
   input  logic                abort,
   input  logic                stuff_req,
   output logic                shift_strobe,
   output logic                byte_done,
   output logic [CNT_BITS-1:0] bit_index,
   output logic                stuff_active,
   output logic                busy,
   output logic                eop_se0
);

   localparam logic [CNT_BITS-1:0] CLK_ROLL = CNT_BITS'(CLKS_PER_BIT);
   localparam logic [CNT_BITS-1:0] CLK_PRE  = CNT_BITS'(CLKS_PER_BIT - 1);
   localparam logic [CNT_BITS-1:0] BIT_ROLL = CNT_BITS'(BITS_PER_BYTE);
   localparam logic [CNT_BITS-1:0] BIT_LAST = CNT_BITS'(BITS_PER_BYTE - 1);
   localparam logic [CNT_BITS-1:0] EOP_ROLL = CNT_BITS'(USB_EOP_BITS);
`ifdef TX_EOP_TIMER_EN
   localparam tx_timer_state_t     HALT_STATE   = EOP;
   localparam logic [CNT_BITS-1:0] EOP_SE0_BITS = CNT_BITS'(USB_EOP_BITS - 1);
`else
   localparam tx_timer_state_t     HALT_STATE   = IDLE;
`endif

   tx_timer_state_t     state_q, state_d;
   logic                stop_latch_q, stop_latch_d;
   logic                stuff_active_q, stuff_active_d;
   logic                byte_done_q, byte_done_d;
   logic                busy_q, busy_d;
   logic [CNT_BITS-1:0] bit_index_q, bit_index_d;

   logic [CNT_BITS-1:0] clk_cnt, bit_cnt, bit_roll;
   logic                clk_flag, bit_flag;
   logic                clk_clear, clk_en, bit_clear, bit_en;
   logic                strobe_next, data_strobe, byte_end, stop_cond;

   // A byte boundary is the data strobe completing the last bit, or the end of a
   // stuffed bit requested on that strobe (bit_index is still 0 during it).
   always_comb begin
      stop_cond = stop_latch_q | stop;
      byte_end  = clk_flag & ((byte_done_q & ~stuff_req) |
                              (stuff_active_q & (bit_index_q == '0)));
      state_d   = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (byte_end && stop_cond) state_d = HALT_STATE;
         EOP:     if (bit_flag) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_comb begin
      clk_clear   = (state_q == IDLE) || (state_d == IDLE);
      clk_en      = ~clk_clear;
      strobe_next = clk_en && (clk_cnt == CLK_PRE);
      data_strobe = strobe_next && (state_q == RUN) && !stuff_active_q;
      byte_done_d = data_strobe && (bit_cnt == BIT_LAST);
      bit_clear   = clk_clear | byte_done_d;
      bit_en      = data_strobe | (strobe_next && (state_q == EOP));
      bit_roll    = (state_q == EOP) ? EOP_ROLL : BIT_ROLL;

      if ((state_d != RUN) || bit_clear) begin
         bit_index_d = '0;
      end else if (bit_en) begin
         bit_index_d = bit_cnt + CNT_BITS'(1);
      end else begin
         bit_index_d = bit_cnt;
      end

      stuff_active_d = stuff_active_q;
      if (clk_flag) stuff_active_d = stuff_active_q ? 1'b0 : stuff_req;
      if (state_d != RUN) stuff_active_d = 1'b0;

      stop_latch_d = (state_d == RUN) && (stop_latch_q || stop);
      busy_d       = (state_d != IDLE);
   end

   flex_counter #(.NUM_CNT_BITS(CNT_BITS)) u_clk_div (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clk_clear),
      .count_enable  (clk_en),
      .rollover_val  (CLK_ROLL),
      .count_out     (clk_cnt),
      .rollover_flag (clk_flag)
   );

   flex_counter #(.NUM_CNT_BITS(CNT_BITS)) u_bit_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (bit_clear),
      .count_enable  (bit_en),
      .rollover_val  (bit_roll),
      .count_out     (bit_cnt),
      .rollover_flag (bit_flag)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= IDLE;
         stop_latch_q   <= 1'b0;
         stuff_active_q <= 1'b0;
         byte_done_q    <= 1'b0;
         busy_q         <= 1'b0;
         bit_index_q    <= '0;
      end else begin
         state_q        <= state_d;
         stop_latch_q   <= stop_latch_d;
         stuff_active_q <= stuff_active_d;
         byte_done_q    <= byte_done_d;
         busy_q         <= busy_d;
         bit_index_q    <= bit_index_d;
      end
   end

`ifdef TX_EOP_TIMER_EN
   logic eop_se0_q, eop_se0_d;

   // SE0 for the first two EOP bit times; bit_cnt counts completed EOP bits.
   assign eop_se0_d = (state_d == EOP) && (bit_cnt < EOP_SE0_BITS);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         eop_se0_q <= 1'b0;
      end else begin
         eop_se0_q <= eop_se0_d;
      end
   end

   assign eop_se0 = eop_se0_q;
`else
   assign eop_se0 = 1'b0;
`endif

   assign shift_strobe = clk_flag;
   assign byte_done    = byte_done_q;
   assign bit_index    = bit_index_q;
   assign stuff_active = stuff_active_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_usb_tx_timer.sv
// Bench for usb_tx_timer: scenario table, hand sequences and random stimulus
// checked every cycle against a cycle-count based reference model.
module tb_usb_tx_timer;

   localparam int CLKS     = 8;
   localparam int BITS     = 8;
   localparam int CNT_BITS = 4;
`ifdef TX_EOP_TIMER_EN
   localparam bit EOP_ON = 1'b1;
`else
   localparam bit EOP_ON = 1'b0;
`endif
   localparam int EOP_CYCLES  = EOP_ON ? 3 * CLKS : 0;
   localparam int EOP_STROBES = EOP_ON ? 3 : 0;

   logic                clk = 1'b0;
   logic                n_rst, start, stop, abort, stuff_req;
   logic                shift_strobe, byte_done, stuff_active, busy, eop_se0;
   logic [CNT_BITS-1:0] bit_index;

   int vectors     = 0;
   int miscompares = 0;

   usb_tx_timer #(.CLKS_PER_BIT(CLKS), .BITS_PER_BYTE(BITS), .CNT_BITS(CNT_BITS)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .stop         (stop),
      .abort        (abort),
      .stuff_req    (stuff_req),
      .shift_strobe (shift_strobe),
      .byte_done    (byte_done),
      .bit_index    (bit_index),
      .stuff_active (stuff_active),
      .busy         (busy),
      .eop_se0      (eop_se0)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 run, 2 eop; time measured in cycles.
   int   m_mode, m_s, m_e, m_bits;
   logic m_stuff, m_sab, m_latch;
   logic e_strobe, e_bd, e_stuff, e_busy, e_se0;
   logic [CNT_BITS-1:0] e_idx;

   task automatic model_clear();
      m_mode = 0; m_s = 0; m_e = 0; m_bits = 0;
      m_stuff = 0; m_sab = 0; m_latch = 0;
      e_strobe = 0; e_bd = 0; e_stuff = 0; e_busy = 0; e_se0 = 0; e_idx = '0;
   endtask

   task automatic model_edge(input logic st, input logic sp, input logic ab, input logic sr);
      logic p_strobe, p_bd, p_stuff, halt;
      p_strobe = e_strobe;
      p_bd     = e_bd;
      p_stuff  = m_stuff;
      if (ab) begin
         model_clear();
         return;
      end
      case (m_mode)
         0: if (st) begin
               m_mode = 1; m_s = 0; m_bits = 0; m_stuff = 0; m_sab = 0; m_latch = sp;
               e_strobe = 0; e_bd = 0; e_idx = '0; e_stuff = 0; e_busy = 1; e_se0 = 0;
            end
         1: begin
               m_latch = m_latch | sp;
               halt = p_strobe && m_latch && ((p_bd && !sr) || (p_stuff && m_sab));
               if (halt) begin
                  if (EOP_ON) begin
                     m_mode = 2; m_e = 0;
                     e_strobe = 0; e_bd = 0; e_idx = '0; e_stuff = 0; e_busy = 1; e_se0 = 1;
                  end else begin
                     model_clear();
                  end
               end else begin
                  m_s++;
                  e_strobe = (m_s % CLKS == 0);
                  e_bd = 0;
                  if (e_strobe && !p_stuff) begin
                     m_bits++;
                     if (m_bits == BITS) begin
                        m_bits = 0;
                        e_bd = 1;
                     end
                  end
                  if (p_strobe) begin
                     if (p_stuff) m_stuff = 0;
                     else if (sr) begin
                        m_stuff = 1;
                        m_sab = p_bd;
                     end
                  end
                  e_idx = CNT_BITS'(m_bits); e_stuff = m_stuff; e_busy = 1; e_se0 = 0;
               end
            end
         default: begin
               m_e++;
               if (m_e == 3 * CLKS) model_clear();
               else begin
                  e_strobe = (m_e % CLKS == CLKS - 1);
                  e_se0 = (m_e < 2 * CLKS);
                  e_bd = 0; e_idx = '0; e_stuff = 0; e_busy = 1;
               end
            end
      endcase
   endtask

   task automatic check_outputs(input string tag);
      logic [8:0] act, exp;
      act = {shift_strobe, byte_done, bit_index, stuff_active, busy, eop_se0};
      exp = {e_strobe, e_bd, e_idx, e_stuff, e_busy, e_se0};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t outputs{strb,bd,idx,stuff,busy,se0} got %b expected %b",
                  tag, $time, act, exp);
      end
   endtask

   task automatic cmp(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic st, input logic sp, input logic ab, input logic sr);
      start = st; stop = sp; abort = ab; stuff_req = sr;
      @(posedge clk);
      model_edge(st, sp, ab, sr);
      #1;
      check_outputs("cycle");
   endtask

   typedef struct {
      int stuff_idx;   // strobe number (1-based) on which stuff_req is raised, 0 = none
      int stop_cyc;    // stop held high from this cycle on, -1 = never
      int abort_cyc;   // abort sampled on this edge, -1 = never
      int exp_first_bd;
      int exp_n_bd;
      int exp_drop;    // first cycle with busy low (non-EOP build)
      int exp_n_strobe;
   } scen_t;

   scen_t scen[6];

   initial begin
      scen[0] = '{0,  0, -1, 64, 1,  65,  8};
      scen[1] = '{3,  0, -1, 72, 1,  73,  9};
      scen[2] = '{0, 70, -1, 64, 2, 129, 16};
      scen[3] = '{0, -1, 41, -1, 0,  41,  5};
      scen[4] = '{8,  0, -1, 64, 1,  73,  9};
      scen[5] = '{2, 100, -1, 72, 2, 137, 17};

      n_rst = 1'b0; start = 0; stop = 0; abort = 0; stuff_req = 0;
      model_clear();
      repeat (3) @(posedge clk);
      #1 check_outputs("reset_state");
      @(negedge clk);
      n_rst = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      for (int si = 0; si < 6; si++) begin
         int first_bd, n_bd, drop, n_str;
         logic stuff_pend;
         first_bd = -1; n_bd = 0; drop = -1; n_str = 0; stuff_pend = 0;
         for (int c = 0; c < 200; c++) begin
            step(c == 0, (scen[si].stop_cyc >= 0) && (c >= scen[si].stop_cyc),
                 c == scen[si].abort_cyc, stuff_pend);
            if (byte_done) begin
               n_bd++;
               if (first_bd < 0) first_bd = c;
            end
            if (shift_strobe) begin
               n_str++;
               stuff_pend = (n_str == scen[si].stuff_idx);
            end else begin
               stuff_pend = 0;
            end
            if (!busy && drop < 0) drop = c;
         end
         $display("scenario %0d: first_bd=%0d n_bd=%0d busy_drop=%0d strobes=%0d",
                  si, first_bd, n_bd, drop, n_str);
         cmp($sformatf("s%0d_first_byte_done", si), first_bd, scen[si].exp_first_bd);
         cmp($sformatf("s%0d_byte_done_count", si), n_bd, scen[si].exp_n_bd);
         cmp($sformatf("s%0d_busy_drop", si), drop,
             scen[si].exp_drop + ((scen[si].abort_cyc < 0) ? EOP_CYCLES : 0));
         cmp($sformatf("s%0d_strobe_count", si), n_str,
             scen[si].exp_n_strobe + ((scen[si].abort_cyc < 0) ? EOP_STROBES : 0));
         step(0, 0, 1, 0);
      end

      // Asynchronous reset in the middle of a byte.
      begin
         int n_str;
         step(1, 0, 0, 0);
         for (int c = 1; c <= 13; c++) step(0, 0, 0, 0);
         n_rst = 1'b0;
         #1;
         model_clear();
         check_outputs("async_reset_mid_run");
         repeat (2) @(negedge clk);
         n_rst = 1'b1;
         n_str = 0;
         for (int c = 0; c < 20; c++) begin
            step(0, 0, 0, 0);
            if (shift_strobe) n_str++;
         end
         $display("reset mid-run: strobes after release=%0d", n_str);
         cmp("no_strobe_after_reset", n_str, 0);
      end

      // Abort mid-byte then restart.
      begin
         int first_str;
         step(1, 0, 0, 0);
         for (int c = 1; c <= 40; c++) step(0, 0, 0, 0);
         step(0, 0, 1, 0);
         cmp("abort_busy", int'(busy), 0);
         cmp("abort_bit_index", int'(bit_index), 0);
         for (int c = 42; c <= 49; c++) step(0, 0, 0, 0);
         step(1, 0, 0, 0);
         first_str = -1;
         for (int c = 51; c <= 70; c++) begin
            step(0, 0, 0, 0);
            if (shift_strobe && first_str < 0) first_str = c;
         end
         $display("abort/restart: first strobe after restart at cycle %0d", first_str);
         cmp("restart_first_strobe", first_str, 58);
         step(0, 0, 1, 0);
      end

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0);
      end
      $display("random: 3000 cycles applied");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
